// File: rtl/mem_initiator_if.sv
// Request/response and memory-side signals of the byte-wide memory initiator.
// master: the initiator itself; slave: the CPU datapath and memory around it.
interface mem_initiator_if #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 3
);
  logic                      reqValid;
  logic                      reqReady;
  logic                      reqWrite;
  logic [1:0]                reqLen;
  logic [ADDR_W-1:0]         reqAddr;
  logic [DATA_W*MAX_LEN-1:0] reqWData;
  logic                      rspValid;
  logic [DATA_W*MAX_LEN-1:0] rspData;
  logic                      memRead;
  logic                      memWrite;
  logic [ADDR_W-1:0]         addressMem;
  logic [DATA_W-1:0]         dataMem;
  logic [DATA_W-1:0]         memOut;

  modport master (
    input  reqValid, reqWrite, reqLen, reqAddr, reqWData, memOut,
    output reqReady, rspValid, rspData,
    output memRead, memWrite, addressMem, dataMem
  );

  modport slave (
    output reqValid, reqWrite, reqLen, reqAddr, reqWData, memOut,
    input  reqReady, rspValid, rspData,
    input  memRead, memWrite, addressMem, dataMem
  );
endinterface

// File: rtl/mem_initiator.sv
// Sequences 1-3 byte reads/writes to the byte-wide memory with strobe/hold
// spacing and returns assembled read data with a one-cycle response pulse.
module mem_initiator #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 3
) (
  input logic              clock,
  input logic              reset,
  mem_initiator_if.master  bus
);
  localparam int RSP_W = DATA_W * MAX_LEN;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR_STROBE,
    WR_HOLD,
    DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_k;
  logic [1:0]          w_k_next;
  logic [1:0]          r_len;
  logic [1:0]          w_len_eff;
  logic [ADDR_W-1:0]   r_base;
  logic [RSP_W-1:0]    r_wdata;
  logic                r_ready;
  logic                r_rsp_valid;
  logic                r_mem_rd;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_addr_mem;
  logic [DATA_W-1:0]   r_data_mem;
  logic [RSP_W-1:0]    r_rsp_data;
  logic                w_accept;
  logic                w_last;
  logic [ADDR_W-1:0]   w_base;
  logic [RSP_W-1:0]    w_wsrc;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_byte;

  assign w_accept  = (r_state == IDLE) && r_ready && bus.reqValid;
  assign w_len_eff = (bus.reqLen == 2'd0) ? 2'd1 : bus.reqLen;
  assign w_last    = (r_k == r_len - 2'd1);

  always_comb begin
    w_next   = r_state;
    w_k_next = r_k;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next   = bus.reqWrite ? WR_STROBE : RD_ISSUE;
          w_k_next = 2'd0;
        end
      end
      RD_ISSUE:  w_next = RD_CAPTURE;
      RD_CAPTURE: begin
        if (w_last) begin
          w_next = DONE;
        end else begin
          w_next   = RD_ISSUE;
          w_k_next = r_k + 2'd1;
        end
      end
      WR_STROBE: w_next = WR_HOLD;
      WR_HOLD: begin
        if (w_last) begin
          w_next = DONE;
        end else begin
          w_next   = WR_STROBE;
          w_k_next = r_k + 2'd1;
        end
      end
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Address/data for the next strobe are computed one cycle early so the
  // memory pins come straight from flops.
  assign w_base = w_accept ? bus.reqAddr : r_base;
  assign w_wsrc = w_accept ? bus.reqWData : r_wdata;
  assign w_addr = w_base + ADDR_W'(w_k_next);
  assign w_byte = w_wsrc[DATA_W*int'(w_k_next) +: DATA_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_len       <= '0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_addr_mem  <= '0;
      r_data_mem  <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_next;
      r_k         <= w_k_next;
      r_ready     <= (w_next == IDLE);
      r_rsp_valid <= (w_next == DONE);
      r_mem_rd    <= (w_next == RD_ISSUE);
      r_mem_wr    <= (w_next == WR_STROBE);
      if (w_accept) begin
        r_base  <= bus.reqAddr;
        r_wdata <= bus.reqWData;
        r_len   <= w_len_eff;
      end
      if (w_accept && !bus.reqWrite) begin
        r_rsp_data <= '0;
      end
      if ((w_next == RD_ISSUE) || (w_next == WR_STROBE)) begin
        r_addr_mem <= w_addr;
      end
      if (w_next == WR_STROBE) begin
        r_data_mem <= w_byte;
      end
      if (r_state == RD_CAPTURE) begin
        r_rsp_data[DATA_W*int'(r_k) +: DATA_W] <= bus.memOut;
      end
    end
  end

  assign bus.reqReady   = r_ready;
  assign bus.rspValid   = r_rsp_valid;
  assign bus.rspData    = r_rsp_data;
  assign bus.memRead    = r_mem_rd;
  assign bus.memWrite   = r_mem_wr;
  assign bus.addressMem = r_addr_mem;
  assign bus.dataMem    = r_data_mem;
endmodule
